// File: rtl/spi_slave_if.sv
// Pin-side and controller-side signal bundle for the SPI slave endpoint.
interface spi_slave_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  SCLK;
    logic                  CS;
    logic                  MOSI;
    logic                  MISO;
    logic                  misoEn;
    logic [DATA_WIDTH-1:0] slaveDataToSend;
    logic                  slaveLoad;
    logic                  txFull;
    logic [DATA_WIDTH-1:0] slaveDataReceived;
    logic                  rxValid;
    logic                  txUnderrun;
    logic                  aborted;
    logic                  busy;

    modport slave (
        input  SCLK, CS, MOSI, slaveDataToSend, slaveLoad,
        output MISO, misoEn, txFull, slaveDataReceived, rxValid, txUnderrun, aborted, busy
    );

    modport master (
        output SCLK, CS, MOSI, slaveDataToSend, slaveLoad,
        input  MISO, misoEn, txFull, slaveDataReceived, rxValid, txUnderrun, aborted, busy
    );
endinterface

// File: rtl/spi_slave.sv
// SPI slave endpoint: synchronized pins, LSB-first RX shift on SCLK fall,
// TX shift from a holding register onto MISO on SCLK rise.
module spi_slave #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    spi_slave_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sclk_pipe;
    logic [SYNC_STAGES-1:0] r_cs_pipe;
    logic [SYNC_STAGES-1:0] r_mosi_pipe;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;

    logic w_sclk_s, w_cs_s, w_mosi_s;
    logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic w_start, w_drive, w_sample, w_last, w_abort, w_stop;

    logic [DATA_WIDTH-1:0] r_tx_hold;
    logic                  r_tx_full;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic [DATA_WIDTH-1:0] w_rx_next;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_miso;
    logic                  r_miso_en;
    logic                  r_rx_valid;
    logic                  r_underrun;
    logic                  r_aborted;
    logic                  r_busy;

    // Pin synchronizers; CS idles high so its chain resets to 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sclk_pipe <= '0;
            r_cs_pipe   <= '1;
            r_mosi_pipe <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_pipe <= {r_sclk_pipe[SYNC_STAGES-2:0], bus.SCLK};
            r_cs_pipe   <= {r_cs_pipe[SYNC_STAGES-2:0], bus.CS};
            r_mosi_pipe <= {r_mosi_pipe[SYNC_STAGES-2:0], bus.MOSI};
            r_sclk_prev <= w_sclk_s;
            r_cs_prev   <= w_cs_s;
        end
    end

    assign w_sclk_s    = r_sclk_pipe[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_pipe[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_pipe[SYNC_STAGES-1];
    assign w_sclk_rise = (w_sclk_s ^ r_sclk_prev) & w_sclk_s;
    assign w_sclk_fall = (w_sclk_s ^ r_sclk_prev) & ~w_sclk_s;
    assign w_cs_fall   = (w_cs_s ^ r_cs_prev) & ~w_cs_s;
    assign w_cs_rise   = (w_cs_s ^ r_cs_prev) & w_cs_s;
    assign w_rx_next   = {w_mosi_s, r_rx_shift[DATA_WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // A CS rise takes priority over a coincident SCLK fall.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_cs_fall) w_state_nxt = S_ACTIVE;
            S_ACTIVE: begin
                if (w_cs_rise)
                    w_state_nxt = S_IDLE;
                else if (w_sclk_fall && (r_cnt == CNT_W'(DATA_WIDTH - 1)))
                    w_state_nxt = S_DONE;
            end
            S_DONE:   if (w_cs_rise) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_start  = 1'b0;
        w_drive  = 1'b0;
        w_sample = 1'b0;
        w_last   = 1'b0;
        w_abort  = 1'b0;
        w_stop   = 1'b0;
        case (r_state)
            S_IDLE:   w_start = w_cs_fall;
            S_ACTIVE: begin
                if (w_cs_rise) begin
                    w_abort = 1'b1;
                    w_stop  = 1'b1;
                end else begin
                    w_drive  = w_sclk_rise;
                    w_sample = w_sclk_fall;
                    w_last   = w_sclk_fall && (r_cnt == CNT_W'(DATA_WIDTH - 1));
                end
            end
            S_DONE:   w_stop = w_cs_rise;
            default:  ;
        endcase
    end

    // Holding register: a load wins over the consume at transfer start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_hold <= '0;
            r_tx_full <= 1'b0;
        end else if (bus.slaveLoad) begin
            r_tx_hold <= bus.slaveDataToSend;
            r_tx_full <= 1'b1;
        end else if (w_start) begin
            r_tx_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_cnt      <= '0;
            r_miso     <= 1'b0;
            r_miso_en  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
            r_aborted  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rx_valid <= w_last;
            r_underrun <= w_start & ~r_tx_full;
            r_aborted  <= w_abort;
            r_busy     <= (w_state_nxt != S_IDLE);
            if (w_start) begin
                r_tx_shift <= r_tx_full ? r_tx_hold : '0;
                r_cnt      <= '0;
                r_miso     <= 1'b0;
                r_miso_en  <= 1'b1;
            end
            if (w_drive) begin
                r_miso     <= r_tx_shift[0];
                r_tx_shift <= r_tx_shift >> 1;
            end
            if (w_sample) begin
                r_rx_shift <= w_rx_next;
                r_cnt      <= r_cnt + CNT_W'(1);
            end
            if (w_last) r_rx_data <= w_rx_next;
            if (w_stop) begin
                r_miso    <= 1'b0;
                r_miso_en <= 1'b0;
            end
        end
    end

    assign bus.MISO              = r_miso;
    assign bus.misoEn            = r_miso_en;
    assign bus.txFull            = r_tx_full;
    assign bus.slaveDataReceived = r_rx_data;
    assign bus.rxValid           = r_rx_valid;
    assign bus.txUnderrun        = r_underrun;
    assign bus.aborted           = r_aborted;
    assign bus.busy              = r_busy;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a vector table of whole transfers plus
// hand-written reset and mid-transfer reset sequences.
module tb_spi_slave;
    logic clk;
    logic reset;

    spi_slave_if #(.DATA_WIDTH(8)) bus ();

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int n_rxv = 0, n_und = 0, n_abt = 0, n_consec = 0;
    logic p_rxv = 1'b0, p_und = 1'b0, p_abt = 1'b0;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.rxValid === 1'b1)    n_rxv++;
        if (bus.txUnderrun === 1'b1) n_und++;
        if (bus.aborted === 1'b1)    n_abt++;
        if ((bus.rxValid === 1'b1 && p_rxv) || (bus.txUnderrun === 1'b1 && p_und) ||
            (bus.aborted === 1'b1 && p_abt))
            n_consec++;
        p_rxv = (bus.rxValid === 1'b1);
        p_und = (bus.txUnderrun === 1'b1);
        p_abt = (bus.aborted === 1'b1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_byte(input logic [7:0] b);
        @(negedge clk);
        bus.slaveDataToSend = b;
        bus.slaveLoad       = 1'b1;
        @(negedge clk);
        bus.slaveLoad       = 1'b0;
    endtask

    // One master transfer; SCLK half period is 4 clk, MISO sampled just before each fall.
    task automatic xfer(input logic [7:0] tx, input int nbits, input int extra,
                        input bit col, input logic [7:0] colb,
                        output logic [7:0] rxm, output logic full_start,
                        output logic en_mid, output logic busy_mid);
        rxm = 8'h00;
        @(negedge clk);
        bus.CS = 1'b0;
        if (col) begin
            repeat (2) @(negedge clk);
            bus.slaveDataToSend = colb;
            bus.slaveLoad       = 1'b1;
            @(negedge clk);
            bus.slaveLoad       = 1'b0;
            repeat (3) @(negedge clk);
        end else begin
            repeat (6) @(negedge clk);
        end
        full_start = bus.txFull;
        en_mid     = bus.misoEn;
        busy_mid   = bus.busy;
        for (int i = 0; i < nbits + extra; i++) begin
            if (i < 8) bus.MOSI = tx[i];
            else       bus.MOSI = 1'b0;
            bus.SCLK = 1'b1;
            repeat (4) @(negedge clk);
            if (i < 8) rxm[i] = bus.MISO;
            bus.SCLK = 1'b0;
            repeat (4) @(negedge clk);
        end
        bus.CS = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    typedef struct {
        bit         do_load;
        logic [7:0] load_b;
        bit         col;
        logic [7:0] col_b;
        logic [7:0] mosi;
        int         nbits;
        int         extra;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        int         exp_rxv;
        int         exp_und;
        int         exp_abt;
        logic       exp_full_start;
        logic       exp_full_end;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0] rxm;
        logic       fs, en_mid, busy_mid;
        int         b_rxv, b_und, b_abt;

        vecs[0] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h5A, 8, 0, 8'h5A, 8'h00, 1, 1, 0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h3C, 1'b0, 8'h00, 8'hA5, 8, 0, 8'hA5, 8'h3C, 1, 0, 0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h99, 1'b0, 8'h00, 8'h0F, 4, 0, 8'hA5, 8'h09, 0, 0, 1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h11, 1'b0, 8'h00, 8'hF0, 8, 2, 8'hF0, 8'h11, 1, 0, 0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h22, 1'b0, 8'h00, 8'h0F, 8, 0, 8'h0F, 8'h22, 1, 0, 0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h77, 1'b1, 8'h88, 8'h3C, 8, 0, 8'h3C, 8'h77, 1, 0, 0, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h81, 8, 0, 8'h81, 8'h88, 1, 0, 0, 1'b0, 1'b0};

        reset               = 1'b0;
        bus.SCLK            = 1'b0;
        bus.CS              = 1'b1;
        bus.MOSI            = 1'b0;
        bus.slaveLoad       = 1'b0;
        bus.slaveDataToSend = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        chk("reset_miso",   32'(bus.MISO), 32'd0);
        chk("reset_misoen", 32'(bus.misoEn), 32'd0);
        chk("reset_txfull", 32'(bus.txFull), 32'd0);
        chk("reset_rxdata", 32'(bus.slaveDataReceived), 32'd0);
        chk("reset_busy",   32'(bus.busy), 32'd0);
        chk("reset_pulses", 32'(n_rxv + n_und + n_abt), 32'd0);

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].do_load) load_byte(vecs[v].load_b);
            b_rxv = n_rxv; b_und = n_und; b_abt = n_abt;
            xfer(vecs[v].mosi, vecs[v].nbits, vecs[v].extra, vecs[v].col, vecs[v].col_b,
                 rxm, fs, en_mid, busy_mid);
            chk($sformatf("v%0d_rxdata", v),     32'(bus.slaveDataReceived), 32'(vecs[v].exp_rx));
            chk($sformatf("v%0d_miso_byte", v),  32'(rxm), 32'(vecs[v].exp_miso));
            chk($sformatf("v%0d_rxvalid", v),    32'(n_rxv - b_rxv), 32'(vecs[v].exp_rxv));
            chk($sformatf("v%0d_underrun", v),   32'(n_und - b_und), 32'(vecs[v].exp_und));
            chk($sformatf("v%0d_aborted", v),    32'(n_abt - b_abt), 32'(vecs[v].exp_abt));
            chk($sformatf("v%0d_full_start", v), 32'(fs), 32'(vecs[v].exp_full_start));
            chk($sformatf("v%0d_full_end", v),   32'(bus.txFull), 32'(vecs[v].exp_full_end));
            chk($sformatf("v%0d_en_mid", v),     32'(en_mid), 32'd1);
            chk($sformatf("v%0d_busy_mid", v),   32'(busy_mid), 32'd1);
            chk($sformatf("v%0d_miso_idle", v),  32'(bus.MISO), 32'd0);
            chk($sformatf("v%0d_en_idle", v),    32'(bus.misoEn), 32'd0);
            chk($sformatf("v%0d_busy_idle", v),  32'(bus.busy), 32'd0);
        end

        // Reset in the middle of a transfer, after three bits.
        load_byte(8'hFF);
        @(negedge clk);
        bus.CS = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.MOSI = 1'b1;
            bus.SCLK = 1'b1;
            repeat (4) @(negedge clk);
            bus.SCLK = 1'b0;
            repeat (4) @(negedge clk);
        end
        bus.SCLK = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_reset_miso", 32'(bus.MISO), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_miso",   32'(bus.MISO), 32'd0);
        chk("async_misoen", 32'(bus.misoEn), 32'd0);
        chk("async_txfull", 32'(bus.txFull), 32'd0);
        chk("async_rxdata", 32'(bus.slaveDataReceived), 32'd0);
        chk("async_busy",   32'(bus.busy), 32'd0);
        chk("async_pulses", 32'({bus.rxValid, bus.txUnderrun, bus.aborted}), 32'd0);
        bus.SCLK = 1'b0;
        bus.CS   = 1'b1;
        bus.MOSI = 1'b0;
        repeat (3) @(negedge clk);
        b_rxv = n_rxv; b_und = n_und; b_abt = n_abt;
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_reset_pulses", 32'((n_rxv - b_rxv) + (n_und - b_und) + (n_abt - b_abt)), 32'd0);
        chk("post_reset_busy",   32'(bus.busy), 32'd0);

        load_byte(8'h3C);
        b_rxv = n_rxv; b_und = n_und; b_abt = n_abt;
        xfer(8'hC3, 8, 0, 1'b0, 8'h00, rxm, fs, en_mid, busy_mid);
        chk("fresh_rxdata",   32'(bus.slaveDataReceived), 32'hC3);
        chk("fresh_miso",     32'(rxm), 32'h3C);
        chk("fresh_rxvalid",  32'(n_rxv - b_rxv), 32'd1);
        chk("fresh_underrun", 32'(n_und - b_und), 32'd0);
        chk("fresh_aborted",  32'(n_abt - b_abt), 32'd0);

        chk("pulse_consecutive", 32'(n_consec), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
